// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   PC generator and fetch queue sitting directly in front of a synchronous
//   instruction memory with a 1-cycle read latency (word index = pc/4).
//   A PC is driven on imem_pc every cycle. Whenever queue space is
//   guaranteed, that PC is issued. Its data returns one cycle later and is
//   captured, together with its PC, into a small FIFO whose head is
//   presented to decode.
//
// Optional feature (macro FETCH_FAST_REDIRECT_EN):
//   When this macro is defined, a redirect drives the aligned target onto
//   imem_pc in the redirect cycle itself. The target fetch is therefore
//   issued immediately, and the redirect latency drops from 3 cycles to 2.
//
// Parameters:
//   RESET_PC    first PC fetched after reset (4-byte aligned)
//   FIFO_DEPTH  fetch queue entries (>= 2)
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   imem_pc        instruction memory address (combinational)
//   imem_instr     memory read data, valid the cycle after an issue
//   branch_taken   redirect request from execute (highest priority)
//   branch_target  redirect PC, bits [1:0] ignored
//   if_valid/if_pc/if_instr  FIFO head towards decode
//   id_ready       decode accepts the head this cycle
//
// Handshake: the head entry transfers on a rising edge where
//   if_valid && id_ready && !branch_taken. A redirect flushes the queue, and
//   decode's id_ready is ignored in that cycle. While the queue is empty,
//   if_pc and if_instr keep their last values.
// ---------------------------------------------------------------------------
`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module fetch_unit #(
    parameter logic [`WORD-1:0] RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [`WORD-1:0]      imem_pc,
    input  logic [`INSTR_LEN-1:0] imem_instr,
    input  logic                  branch_taken,
    input  logic [`WORD-1:0]      branch_target,
    output logic                  if_valid,
    output logic [`WORD-1:0]      if_pc,
    output logic [`INSTR_LEN-1:0] if_instr,
    input  logic                  id_ready
);

    localparam int               CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [`WORD-1:0] PC_STEP = `WORD'(4);

    logic [`WORD-1:0]      fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [`WORD-1:0]      inflight_pc_q, inflight_pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [`WORD-1:0]      fifo_pc_q    [FIFO_DEPTH];
    logic [`WORD-1:0]      fifo_pc_d    [FIFO_DEPTH];
    logic [`INSTR_LEN-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [`INSTR_LEN-1:0] fifo_instr_d [FIFO_DEPTH];

    logic [`WORD-1:0] target_aligned;
    logic             pop;
    logic             push;
    logic             issue;
    logic [CW:0]      occupancy;
    logic [CW-1:0]    wr_idx;
    logic             unused_target_bits;

    assign target_aligned     = {branch_target[`WORD-1:2], 2'b00};
    assign unused_target_bits = ^branch_target[1:0];

    assign if_valid = (count_q != '0);
    assign if_pc    = fifo_pc_q[0];
    assign if_instr = fifo_instr_q[0];

`ifdef FETCH_FAST_REDIRECT_EN
    assign imem_pc = branch_taken ? target_aligned : fetch_pc_q;
`else
    assign imem_pc = fetch_pc_q;
`endif

    // Entries already queued plus the one returning from memory. Issue is
    // allowed only when that total leaves room, or when a pop frees a slot
    // in the same cycle. This rule prevents a push into a full queue.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign pop       = if_valid & id_ready & ~branch_taken;
    assign push      = inflight_q & ~branch_taken;
    assign issue     = ~branch_taken &
                       ((occupancy < (CW+1)'(FIFO_DEPTH)) | (if_valid & id_ready));
    // After a pop shifts the queue down, the tail slot sits at count - pop.
    assign wr_idx    = count_q - CW'(pop);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;

        if (branch_taken) begin
            // Flush the queue and drop the returning fetch. The storage is
            // left untouched so if_pc/if_instr keep their last values.
            count_d = '0;
`ifdef FETCH_FAST_REDIRECT_EN
            inflight_d    = 1'b1;
            inflight_pc_d = target_aligned;
            fetch_pc_d    = target_aligned + PC_STEP;
`else
            inflight_d    = 1'b0;
            fetch_pc_d    = target_aligned;
`endif
        end else begin
            inflight_d = issue;
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + PC_STEP;
                inflight_pc_d = fetch_pc_q;
            end

            // Shift-register queue with the head in slot 0. Only occupied
            // slots shift, so a pop of the last entry leaves slot 0 as is.
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                if (pop && ((i + 1) < int'(count_q))) begin
                    fifo_pc_d[i]    = fifo_pc_q[i + 1];
                    fifo_instr_d[i] = fifo_instr_q[i + 1];
                end
            end

            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (push && (wr_idx == CW'(i))) begin
                    fifo_pc_d[i]    = inflight_pc_q;
                    fifo_instr_d[i] = imem_instr;
                end
            end

            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit with RESET_PC=0 and FIFO_DEPTH=2.
//   A synchronous memory model returns a PC-derived word one cycle after
//   each address. Drivers push the expected accepted PCs into exp_q.
//   A monitor pops and checks each entry that decode accepts. drain()
//   requires the queue to empty in an exact number of cycles, which pins
//   down both latency and gap-free throughput.
// ---------------------------------------------------------------------------
`ifndef WORD
`define WORD 32
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0;
`ifdef FETCH_FAST_REDIRECT_EN
    localparam int REDIR_LAT = 2;
`else
    localparam int REDIR_LAT = 3;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_pc      (imem_pc),
        .imem_instr   (imem_instr),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .id_ready     (id_ready)
    );

    function automatic logic [31:0] mem_word(input logic [29:0] idx);
        return {8'h13, idx[23:0]} ^ 32'h005A_A500;
    endfunction

    always @(posedge clk) imem_instr <= mem_word(imem_pc[31:2]);

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready && !branch_taken) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_accept: got pc 0x%08h with no entry expected at %0t",
                         if_pc, $time);
            end else begin
                exp_pc = exp_q.pop_front();
                chk("accept_pc", if_pc, exp_pc);
                chk("accept_instr", if_instr, mem_word(exp_pc[31:2]));
            end
        end
    end

    // A capture must never land in a full queue.
    always @(negedge clk) begin
        if (rst_n && !branch_taken && dut.inflight_q && (int'(dut.count_q) == DEPTH)) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_when_full: count %0d inflight 1 at %0t", dut.count_q, $time);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
    endtask

    // Runs exactly until the queue is empty and expects that to take
    // `budget` cycles. It then drops id_ready.
    task automatic drain(input string name, input int budget);
        int used;
        used = 0;
        while (exp_q.size() != 0 && used < budget + 4) begin
            tick();
            used++;
        end
        chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_cycles"}, 32'(used), 32'(budget));
        exp_q.delete();
        id_ready = 1'b0;
    endtask

    task automatic redirect_and_drain(input string name, input logic [31:0] target,
                                      input logic [31:0] first_pc, input int n);
        push_seq(first_pc, n);
        branch_taken  = 1'b1;
        branch_target = target;
        id_ready      = 1'b1;
        tick();
        branch_taken = 1'b0;
        @(negedge clk);
        chk({name, "_valid_after"}, 32'(if_valid), 32'd0);
        drain(name, REDIR_LAT - 1 + n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_imem_pc", imem_pc, RST_PC);

        // Release: PCs 0 and 4 are accepted in cycles 2 and 3.
        rst_n    = 1'b1;
        id_ready = 1'b1;
        push_seq(32'h0, 2);
        drain("startup", 4);

        // Stall with PC 8 at the head.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_pc", if_pc, 32'h8);
            chk("stall_instr", if_instr, mem_word(30'd2));
            chk("stall_imem_pc", imem_pc, 32'h10);
            tick();
        end
        push_seq(32'h8, 4);
        id_ready = 1'b1;
        drain("release", 4);

        // Let the queue fill, then redirect while it is full.
        tick();
        tick();
        @(negedge clk);
        chk("full_valid", 32'(if_valid), 32'd1);
        chk("full_pc", if_pc, 32'h18);
        tick();
        redirect_and_drain("redir_full", 32'h40, 32'h40, 3);

        redirect_and_drain("redir_misaligned", 32'h103, 32'h100, 2);

        // Back-to-back redirects: 0x80 must never surface.
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        tick();
        redirect_and_drain("redir_b2b", 32'hC0, 32'hC0, 2);

        // Fill the queue, then reset asynchronously without a clock edge.
        repeat (3) tick();
        @(negedge clk);
        chk("prerst_valid", 32'(if_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(if_valid), 32'd0);
        chk("async_rst_pc", if_pc, 32'd0);
        chk("async_rst_instr", if_instr, 32'd0);
        chk("async_rst_imem_pc", imem_pc, RST_PC);
        tick();
        rst_n    = 1'b1;
        id_ready = 1'b1;
        push_seq(RST_PC, 3);
        drain("refetch", 5);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
